bypass_ctrl: RTL and testbench
==============================

# bypass_ctrl

Decode-stage hazard and forwarding controller for the 5-stage pipeline. It tracks the destination register of every in-flight instruction in EX, MEM and WB. It drives the regfile bypass selects `EX_D_bp`, `MEM_D_bp` and `WB_D_bp`, each encoded as {forward_ra, forward_rb}. It also detects load-use hazards and issues a one-cycle decode stall with an EX bubble.

## Interface
Parameters:
- `ADDR_SIZE`, 5, register index width
- `CNT_W`, 32, stall counter width

Ports:
- `clk`  in  1  sole clock; all state updates on posedge
- `rst`  in  1  synchronous, active-high reset
- `D_valid`  in  1  decode holds a real instruction
- `D_ra`, `D_rb`  in  ADDR_SIZE  source register indices
- `D_use_ra`, `D_use_rb`  in  1  instruction actually reads ra / rb
- `D_rd`  in  ADDR_SIZE  destination index
- `D_we`  in  1  instruction writes `D_rd`
- `D_ld`  in  1  instruction is a load
- `flush`  in  1  kill the decode instruction (taken branch)
- `ext_stall`  in  1  freeze the whole pipeline (memory wait)
- `EX_D_bp`, `MEM_D_bp`, `WB_D_bp`  out  2  bypass selects, bit1 = ra, bit0 = rb
- `D_stall`  out  1  hold PC and the F/D register this cycle
- `EX_bubble`  out  1  insert a NOP into the EX stage this cycle
- `WB_we_trk`  out  1  WB slot valid and writing (checker tap)
- `stall_cnt`  out  CNT_W  load-use stall cycles since reset

## Operation
- Internal slots EX, MEM and WB each hold {v, rd, we, ld}.
- Slot advance when `ext_stall`=0:
  - WB takes MEM.
  - MEM takes EX.
  - EX takes decode fields, or a bubble (v=0) if `EX_bubble`.
- A slot counts as a writer only when v=1, we=1 and rd≠0. x0 is never forwarded.
- Match for port p in {ra, rb}: `D_valid` & `D_use_p` & slot is a writer & slot.rd == D_p.
- Priority per bit is EX > MEM > WB. At most one of the three bp buses has a given bit set. A lower stage asserts only if no higher stage matches.
- Load-use: the EX slot is a writer with ld=1 and matches ra or rb.
  - Suppress EX forwarding for that bit; load data is not ready.
  - Assert `D_stall`=1 and `EX_bubble`=1.
  - Next cycle the load sits in MEM and `MEM_D_bp` forwards it.
- `flush`=1: `EX_bubble`=1 and `D_stall`=0. Flush overrides load-use; the killed instruction needs no stall.
- `ext_stall`=1:
  - Slots hold; `D_stall`=1; `EX_bubble`=0.
  - bp outputs keep reflecting the current slots.
  - `stall_cnt` does not increment.
- `stall_cnt` increments once per cycle with load-use asserted, flush=0 and ext_stall=0. It saturates at all-ones.
- Reset:
  - Clears all slot v bits and `stall_cnt`.
  - Every output reads 0 the cycle after reset, regardless of decode inputs, since no slot is valid.

## Timing
- Slot state is registered and changes only on posedge.
- All bp, `D_stall` and `EX_bubble` outputs are combinational from the slots and same-cycle decode inputs, with zero latency.
- Forward distance:
  - producer 1 ahead → EX bypass
  - 2 ahead → MEM
  - 3 ahead → WB
  - 4+ ahead → regfile read, no bypass
- Load-use costs exactly one stall cycle. The consumer then gets `MEM_D_bp`.
- Two loads back-to-back feeding a consumer: a single stall, then forwarding from MEM.
- `rst` in mid-stall: the next cycle has `D_stall`=0 and all slots empty; the stalled instruction is re-presented by upstream.
- `flush` and `ext_stall` together: ext_stall wins (freeze), and the flush is re-sampled the next cycle.

## Structure
- `pipe_pkg` holds:
  - the `slot_t` typedef {v, rd, we, ld}
  - `BP_RA`=1 and `BP_RB`=0 bit indices
  - `REG_ZERO` constant
- One sub-module, `bp_match`. It takes one slot and one decode port and outputs a `hit` bit. It is instantiated six times (3 stages × 2 ports).

## Test plan
- ADD x3 then SUB using x3 as ra next cycle → `EX_D_bp`=2'b10; `MEM_D_bp`=`WB_D_bp`=0; no stall.
- Writer x5, then two NOPs, then a reader of x5 on rb → `WB_D_bp`=2'b01. Same pattern with x0 as destination → all bp 0.
- LD x7, then ADD x7,x7 → cycle 1: `D_stall`=1, `EX_bubble`=1, `EX_D_bp`=0. Cycle 2: `MEM_D_bp`=2'b11, `stall_cnt`=1.
- x4 written in EX and in MEM, reader of x4 → only `EX_D_bp`[1]=1 (priority).
- Load-use with `flush`=1 → `D_stall`=0, `EX_bubble`=1, `stall_cnt` unchanged. With `ext_stall`=1 instead → slots frozen for 3 cycles and bp outputs stable.
- Assert `rst` during a load-use stall → next cycle all outputs 0 and `stall_cnt`=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the decode-stage bypass controller.
// Register indices are held at a fixed maximum width so slot_t needs no module parameter.
package pipe_pkg;

  localparam int unsigned REG_W_MAX = 8;

  typedef logic [REG_W_MAX-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

  // Bit positions inside each {forward_ra, forward_rb} bypass select
  localparam int unsigned BP_RA = 1;
  localparam int unsigned BP_RB = 0;

  typedef struct packed {
    logic     v;
    reg_idx_t rd;
    logic     we;
    logic     ld;
  } slot_t;

  localparam int unsigned SLOT_W = $bits(slot_t);

endpackage

// File: rtl/bp_match.sv
// Compares one in-flight slot against one decode source port.
// Hits only for a live writer of a non-zero register that the decode instruction actually reads.
module bp_match
  import pipe_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 5
) (
  input  logic [SLOT_W-1:0]    slot_i,
  input  logic                 valid_i,
  input  logic                 use_i,
  input  logic [ADDR_SIZE-1:0] src_i,
  output logic                 hit_o
);

  slot_t slot;
  logic  writer;
  logic  unused_ld;

  assign slot      = slot_t'(slot_i);
  assign unused_ld = slot.ld;

  assign writer = slot.v & slot.we & (slot.rd != REG_ZERO);
  assign hit_o  = valid_i & use_i & writer & (slot.rd == reg_idx_t'(src_i));

endmodule

// File: rtl/bypass_ctrl.sv
// Decode-stage hazard and forwarding controller for the 5-stage pipeline.
// Tracks EX/MEM/WB destinations, drives bypass selects and the load-use stall/bubble.
module bypass_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 5,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 D_valid,
  input  logic [ADDR_SIZE-1:0] D_ra,
  input  logic [ADDR_SIZE-1:0] D_rb,
  input  logic                 D_use_ra,
  input  logic                 D_use_rb,
  input  logic [ADDR_SIZE-1:0] D_rd,
  input  logic                 D_we,
  input  logic                 D_ld,
  input  logic                 flush,
  input  logic                 ext_stall,
  output logic [1:0]           EX_D_bp,
  output logic [1:0]           MEM_D_bp,
  output logic [1:0]           WB_D_bp,
  output logic                 D_stall,
  output logic                 EX_bubble,
  output logic                 WB_we_trk,
  output logic [CNT_W-1:0]     stall_cnt
);

  slot_t ex_q, ex_d, mem_q, wb_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Index 0 = EX, 1 = MEM, 2 = WB
  logic [SLOT_W-1:0] stage_slot [3];
  logic [2:0]        hit_ra;
  logic [2:0]        hit_rb;
  logic              load_use;
  logic              stall_inc;

  assign stage_slot[0] = ex_q;
  assign stage_slot[1] = mem_q;
  assign stage_slot[2] = wb_q;

  for (genvar g = 0; g < 3; g++) begin : g_stage
    bp_match #(
      .ADDR_SIZE(ADDR_SIZE)
    ) u_match_ra (
      .slot_i (stage_slot[g]),
      .valid_i(D_valid),
      .use_i  (D_use_ra),
      .src_i  (D_ra),
      .hit_o  (hit_ra[g])
    );

    bp_match #(
      .ADDR_SIZE(ADDR_SIZE)
    ) u_match_rb (
      .slot_i (stage_slot[g]),
      .valid_i(D_valid),
      .use_i  (D_use_rb),
      .src_i  (D_rb),
      .hit_o  (hit_rb[g])
    );
  end

  // A load in EX has no data yet, so its match becomes a stall instead of a forward
  assign load_use  = (hit_ra[0] | hit_rb[0]) & ex_q.ld;
  assign stall_inc = load_use & ~flush & ~ext_stall;

  always_comb begin
    EX_D_bp  = '0;
    MEM_D_bp = '0;
    WB_D_bp  = '0;

    EX_D_bp[BP_RA]  = hit_ra[0] & ~ex_q.ld;
    EX_D_bp[BP_RB]  = hit_rb[0] & ~ex_q.ld;
    MEM_D_bp[BP_RA] = hit_ra[1] & ~hit_ra[0];
    MEM_D_bp[BP_RB] = hit_rb[1] & ~hit_rb[0];
    WB_D_bp[BP_RA]  = hit_ra[2] & ~hit_ra[1] & ~hit_ra[0];
    WB_D_bp[BP_RB]  = hit_rb[2] & ~hit_rb[1] & ~hit_rb[0];
  end

  // Freeze dominates; a flushed instruction is killed so it never needs the stall
  always_comb begin
    D_stall   = ext_stall | (load_use & ~flush);
    EX_bubble = ~ext_stall & (flush | load_use);
  end

  always_comb begin
    ex_d = '0;
    if (!EX_bubble) begin
      ex_d.v  = D_valid;
      ex_d.rd = reg_idx_t'(D_rd);
      ex_d.we = D_we;
      ex_d.ld = D_ld;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_inc && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else if (!ext_stall) begin
      wb_q        <= mem_q;
      mem_q       <= ex_q;
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign WB_we_trk = wb_q.v & wb_q.we;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_bypass_ctrl.sv
// Self-checking bench for bypass_ctrl: directed hazard scenarios followed by random traffic,
// all checked against a distance-based model of the in-flight instruction history.
module tb_bypass_ctrl;

  localparam int AW = 5;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          D_valid = 1'b0;
  logic [AW-1:0] D_ra = '0;
  logic [AW-1:0] D_rb = '0;
  logic          D_use_ra = 1'b0;
  logic          D_use_rb = 1'b0;
  logic [AW-1:0] D_rd = '0;
  logic          D_we = 1'b0;
  logic          D_ld = 1'b0;
  logic          flush = 1'b0;
  logic          ext_stall = 1'b0;
  logic [1:0]    EX_D_bp, MEM_D_bp, WB_D_bp;
  logic          D_stall, EX_bubble, WB_we_trk;
  logic [CW-1:0] stall_cnt;

  bypass_ctrl #(
    .ADDR_SIZE(AW),
    .CNT_W    (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .D_valid  (D_valid),
    .D_ra     (D_ra),
    .D_rb     (D_rb),
    .D_use_ra (D_use_ra),
    .D_use_rb (D_use_rb),
    .D_rd     (D_rd),
    .D_we     (D_we),
    .D_ld     (D_ld),
    .flush    (flush),
    .ext_stall(ext_stall),
    .EX_D_bp  (EX_D_bp),
    .MEM_D_bp (MEM_D_bp),
    .WB_D_bp  (WB_D_bp),
    .D_stall  (D_stall),
    .EX_bubble(EX_bubble),
    .WB_we_trk(WB_we_trk),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // hist[d] is the instruction issued d+1 cycles ahead of decode
  typedef struct {
    bit v;
    int rd;
    bit we;
    bit ld;
  } ins_t;

  ins_t hist [3];
  int   cnt_m = 0;
  bit   lu_m;
  int   e_bp [3];
  bit   e_stall, e_bub, e_trk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit writer(input ins_t s);
    return s.v && s.we && (s.rd != 0);
  endfunction

  task automatic clear_hist();
    for (int d = 0; d < 3; d++) begin
      hist[d].v  = 0;
      hist[d].rd = 0;
      hist[d].we = 0;
      hist[d].ld = 0;
    end
  endtask

  // Nearest producer wins; a load one ahead cannot forward and forces a stall instead
  task automatic model_eval();
    int  src;
    bit  use_p;
    bit  found;
    int  bitpos;
    lu_m = 0;
    for (int d = 0; d < 3; d++) e_bp[d] = 0;
    for (int p = 0; p < 2; p++) begin
      src    = (p == 0) ? int'(D_ra) : int'(D_rb);
      use_p  = (p == 0) ? D_use_ra : D_use_rb;
      bitpos = (p == 0) ? 1 : 0;
      found  = 0;
      if (D_valid && use_p) begin
        for (int d = 0; d < 3; d++) begin
          if (!found && writer(hist[d]) && hist[d].rd == src) begin
            found = 1;
            if (d == 0 && hist[0].ld) lu_m = 1;
            else e_bp[d] = e_bp[d] | (1 << bitpos);
          end
        end
      end
    end
    e_stall = ext_stall || (lu_m && !flush);
    e_bub   = !ext_stall && (flush || lu_m);
    e_trk   = hist[2].v && hist[2].we;
  endtask

  task automatic eval(input bit chk);
    @(negedge clk);
    model_eval();
    if (chk) begin
      check("EX_D_bp", 32'(EX_D_bp), 32'(e_bp[0]));
      check("MEM_D_bp", 32'(MEM_D_bp), 32'(e_bp[1]));
      check("WB_D_bp", 32'(WB_D_bp), 32'(e_bp[2]));
      check("D_stall", 32'(D_stall), 32'(e_stall));
      check("EX_bubble", 32'(EX_bubble), 32'(e_bub));
      check("WB_we_trk", 32'(WB_we_trk), 32'(e_trk));
      check("stall_cnt", 32'(stall_cnt), 32'(cnt_m));
    end
  endtask

  task automatic adv();
    @(posedge clk);
    if (rst) begin
      clear_hist();
      cnt_m = 0;
    end else if (!ext_stall) begin
      if (lu_m && !flush && cnt_m < CNT_MAX) cnt_m++;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0].v  = e_bub ? 1'b0 : D_valid;
      hist[0].rd = e_bub ? 0 : int'(D_rd);
      hist[0].we = e_bub ? 1'b0 : D_we;
      hist[0].ld = e_bub ? 1'b0 : D_ld;
    end
    #1;
  endtask

  task automatic step();
    eval(1);
    adv();
  endtask

  task automatic set_ins(input int rd, input bit we, input bit ld, input int ra, input bit ura,
                         input int rb, input bit urb);
    D_valid   = 1;
    D_rd      = AW'(rd);
    D_we      = we;
    D_ld      = ld;
    D_ra      = AW'(ra);
    D_use_ra  = ura;
    D_rb      = AW'(rb);
    D_use_rb  = urb;
    flush     = 0;
    ext_stall = 0;
  endtask

  task automatic set_nop();
    set_ins(0, 0, 0, 0, 0, 0, 0);
    D_valid = 0;
  endtask

  task automatic drain();
    repeat (3) begin
      set_nop();
      step();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ex"}, 32'(EX_D_bp), 32'd0);
    check({tag, "_mem"}, 32'(MEM_D_bp), 32'd0);
    check({tag, "_wb"}, 32'(WB_D_bp), 32'd0);
    check({tag, "_stall"}, 32'(D_stall), 32'd0);
    check({tag, "_bub"}, 32'(EX_bubble), 32'd0);
    check({tag, "_trk"}, 32'(WB_we_trk), 32'd0);
    check({tag, "_cnt"}, 32'(stall_cnt), 32'd0);
  endtask

  initial begin
    clear_hist();

    // Reset: slots start unknown, so the first cycle is unchecked
    rst = 1;
    set_nop();
    eval(0);
    adv();
    set_ins(3, 1, 1, 3, 1, 3, 1);
    step();
    rst = 0;
    set_ins(3, 1, 1, 3, 1, 3, 1);
    eval(1);
    check_all_zero("post_rst");
    adv();
    drain();

    // Producer one ahead forwards from EX
    set_ins(3, 1, 0, 1, 1, 2, 1);
    step();
    set_ins(6, 1, 0, 3, 1, 4, 1);
    eval(1);
    check("raw1_ex", 32'(EX_D_bp), 32'd2);
    check("raw1_mem", 32'(MEM_D_bp), 32'd0);
    check("raw1_wb", 32'(WB_D_bp), 32'd0);
    check("raw1_stall", 32'(D_stall), 32'd0);
    adv();
    drain();

    // Producer three ahead forwards from WB; x0 never forwards
    set_ins(5, 1, 0, 0, 0, 0, 0);
    step();
    set_nop();
    step();
    step();
    set_ins(7, 1, 0, 1, 0, 5, 1);
    eval(1);
    check("raw3_wb", 32'(WB_D_bp), 32'd1);
    check("raw3_ex", 32'(EX_D_bp), 32'd0);
    check("raw3_mem", 32'(MEM_D_bp), 32'd0);
    adv();
    drain();
    set_ins(0, 1, 0, 0, 0, 0, 0);
    step();
    set_nop();
    step();
    step();
    set_ins(7, 1, 0, 0, 1, 0, 1);
    eval(1);
    check("x0_wb", 32'(WB_D_bp), 32'd0);
    check("x0_ex", 32'(EX_D_bp), 32'd0);
    check("x0_mem", 32'(MEM_D_bp), 32'd0);
    adv();
    drain();

    // Load-use: one stall cycle, then MEM forwards both ports
    set_ins(7, 1, 1, 1, 1, 2, 0);
    step();
    set_ins(8, 1, 0, 7, 1, 7, 1);
    eval(1);
    check("lu_stall", 32'(D_stall), 32'd1);
    check("lu_bub", 32'(EX_bubble), 32'd1);
    check("lu_ex", 32'(EX_D_bp), 32'd0);
    adv();
    eval(1);
    check("lu_mem", 32'(MEM_D_bp), 32'd3);
    check("lu_cnt", 32'(stall_cnt), 32'd1);
    check("lu_stall2", 32'(D_stall), 32'd0);
    adv();
    drain();

    // Same register in EX and MEM: EX wins
    set_ins(4, 1, 0, 1, 0, 2, 0);
    step();
    step();
    set_ins(9, 1, 0, 4, 1, 10, 0);
    eval(1);
    check("prio_ex", 32'(EX_D_bp), 32'd2);
    check("prio_mem", 32'(MEM_D_bp), 32'd0);
    check("prio_wb", 32'(WB_D_bp), 32'd0);
    adv();
    drain();

    // Flush overrides load-use
    set_ins(9, 1, 1, 1, 0, 2, 0);
    step();
    set_ins(10, 1, 0, 9, 1, 3, 0);
    flush = 1;
    eval(1);
    check("fl_stall", 32'(D_stall), 32'd0);
    check("fl_bub", 32'(EX_bubble), 32'd1);
    adv();
    set_nop();
    eval(1);
    check("fl_cnt", 32'(stall_cnt), 32'd1);
    adv();
    drain();

    // Freeze over a load-use with an older producer in MEM
    set_ins(11, 1, 0, 1, 0, 2, 0);
    step();
    set_ins(9, 1, 1, 1, 0, 2, 0);
    step();
    set_ins(12, 1, 0, 11, 1, 9, 1);
    ext_stall = 1;
    repeat (3) begin
      eval(1);
      check("frz_stall", 32'(D_stall), 32'd1);
      check("frz_bub", 32'(EX_bubble), 32'd0);
      check("frz_ex", 32'(EX_D_bp), 32'd0);
      check("frz_mem", 32'(MEM_D_bp), 32'd2);
      check("frz_cnt", 32'(stall_cnt), 32'd1);
      adv();
    end
    ext_stall = 0;
    eval(1);
    check("thaw_stall", 32'(D_stall), 32'd1);
    check("thaw_bub", 32'(EX_bubble), 32'd1);
    adv();
    eval(1);
    check("thaw_mem", 32'(MEM_D_bp), 32'd1);
    check("thaw_wb", 32'(WB_D_bp), 32'd2);
    check("thaw_cnt", 32'(stall_cnt), 32'd2);
    adv();
    drain();

    // Two back-to-back loads to the same register: single stall
    set_ins(6, 1, 1, 1, 0, 2, 0);
    step();
    step();
    set_ins(13, 1, 0, 6, 1, 2, 0);
    eval(1);
    check("ld2_stall", 32'(D_stall), 32'd1);
    adv();
    eval(1);
    check("ld2_mem", 32'(MEM_D_bp), 32'd2);
    check("ld2_stall2", 32'(D_stall), 32'd0);
    check("ld2_cnt", 32'(stall_cnt), 32'd3);
    adv();
    drain();

    // Reset in the middle of a load-use stall
    set_ins(8, 1, 1, 1, 0, 2, 0);
    step();
    set_ins(14, 1, 0, 8, 1, 2, 0);
    eval(1);
    check("rst_lu_stall", 32'(D_stall), 32'd1);
    rst = 1;
    adv();
    rst = 0;
    eval(1);
    check_all_zero("rst_mid");
    adv();
    drain();

    // Counter saturation with a narrow counter
    for (int i = 0; i < 20; i++) begin
      set_ins(1 + (i % 7), 1, 1, 0, 0, 0, 0);
      step();
      set_ins(20, 1, 0, 0, 0, 1 + (i % 7), 1);
      step();
      step();
    end
    eval(1);
    check("sat_cnt", 32'(stall_cnt), 32'(CNT_MAX));
    adv();

    // Random traffic over a small register window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      set_ins(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)),
              1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
              1'($urandom_range(0, 3) != 0));
      D_valid   = ($urandom_range(0, 9) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      ext_stall = ($urandom_range(0, 9) == 0);
      rst       = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
